// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty control slice: FSM state encodings,
// duty width, and the level-to-select-code encoding used by the PWM generator.
package pwm_pkg;

  localparam int DUTY_W = 4;

  // The PWM generator selects 50 % with code 0 instead of the level 8.
  localparam logic [DUTY_W-1:0] DUTY_HALF_CODE  = 4'b0000;
  localparam logic [DUTY_W-1:0] DUTY_HALF_LEVEL = 4'd8;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2
  } state_t;

  // Maps a duty level in sixteenths to the PWM select code.
  function automatic logic [DUTY_W-1:0] duty_encode(input logic [DUTY_W-1:0] level);
    return (level == DUTY_HALF_LEVEL) ? DUTY_HALF_CODE : level;
  endfunction

endpackage

// File: rtl/pwm_duty_ctrl_tick_gen.sv
// Prescale tick generator for the auto-ramp: counts 0..DIV-1 while enabled
// and pulses tick on the DIV-1 count, then wraps. clr holds the count at 0
// so the first tick comes exactly DIV cycles after clr drops.
module tick_gen #(
  parameter int DIV = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Prescale counter: cleared by clr, advances while enabled, wraps on tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty control stage feeding the 4-bit PWM generator. Holds a duty level in
// sixteenths clamped to DUTY_MIN..DUTY_MAX, stepped manually by up/down or
// ramped automatically ("breathing") on a prescaled tick.
// Build option: define PWM_DUTY_AUTO_EN to build the auto-ramp states and the
// prescale counter; without it only manual mode exists and mode is ignored.
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int TICK_DIV  = 5_000_000,
  parameter int DUTY_MIN  = 2,
  parameter int DUTY_MAX  = 14,
  parameter int DUTY_INIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              up,
  input  logic              down,
  output logic [DUTY_W-1:0] n,
  output logic [DUTY_W-1:0] duty,
  output logic              rising,
  output logic              step
);

  localparam logic [DUTY_W-1:0] MIN_C  = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] MAX_C  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_C = DUTY_W'(DUTY_INIT);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_d;
  logic              mode_auto;
  logic              tick;

`ifdef PWM_DUTY_AUTO_EN
  logic rising_d;

  assign mode_auto = mode;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == S_MANUAL),
    .en    (state_q != S_MANUAL),
    .tick  (tick)
  );

  // Ramp direction follows the auto state it enters; manual keeps the last one.
  always_comb begin
    rising_d = rising;
    if (state_d == S_RISE) rising_d = 1'b1;
    else if (state_d == S_FALL) rising_d = 1'b0;
  end

  // Direction register, reset to rising.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rising <= 1'b1;
    else       rising <= rising_d;
  end
`else
  logic        unused_mode;
  logic [31:0] unused_tick_div;

  // Manual-only build: no ramp, so mode and the prescale divider are not used.
  assign mode_auto       = 1'b0;
  assign tick            = 1'b0;
  assign rising          = 1'b1;
  assign unused_mode     = mode;
  assign unused_tick_div = 32'(TICK_DIV);
`endif

  // Next-state and next-duty: manual steps clamp before the add; auto steps
  // happen on tick and reverse at the bounds. Mode changes never move duty.
  always_comb begin
    state_d = state_q;
    duty_d  = duty;
    unique case (state_q)
      S_MANUAL: begin
        if (mode_auto) begin
          state_d = (duty < MAX_C) ? S_RISE : S_FALL;
        end else if (up && !down && (duty < MAX_C)) begin
          duty_d = duty + 4'd1;
        end else if (down && !up && (duty > MIN_C)) begin
          duty_d = duty - 4'd1;
        end
      end
      S_RISE: begin
        if (!mode_auto) begin
          state_d = S_MANUAL;
        end else if (tick) begin
          if (duty < MAX_C) duty_d = duty + 4'd1;
          if (duty_d >= MAX_C) state_d = S_FALL;
        end
      end
      S_FALL: begin
        if (!mode_auto) begin
          state_d = S_MANUAL;
        end else if (tick) begin
          if (duty > MIN_C) duty_d = duty - 4'd1;
          if (duty_d <= MIN_C) state_d = S_RISE;
        end
      end
      default: state_d = S_MANUAL;
    endcase
  end

  // State, duty, encoded select code and step pulse all update on one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_MANUAL;
      duty    <= INIT_C;
      n       <= duty_encode(INIT_C);
      step    <= 1'b0;
    end else begin
      state_q <= state_d;
      duty    <= duty_d;
      n       <= duty_encode(duty_d);
      step    <= (duty_d != duty);
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: reset values, a table of manual vectors, hand
// sequences for saturation, simultaneous requests, auto ramp and async reset,
// then randomized traffic against a cycle-level reference model.
module tb_pwm_duty_ctrl;

  localparam int TDIV = 4;
  localparam int DMIN = 2;
  localparam int DMAX = 14;
  localparam int DINIT = 8;
`ifdef PWM_DUTY_AUTO_EN
  localparam bit AUTO_BUILD = 1'b1;
`else
  localparam bit AUTO_BUILD = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       mode, up, down;
  logic [3:0] n, duty;
  logic       rising, step;

  int total = 0;
  int bad   = 0;

  pwm_duty_ctrl #(
    .TICK_DIV  (TDIV),
    .DUTY_MIN  (DMIN),
    .DUTY_MAX  (DMAX),
    .DUTY_INIT (DINIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .up     (up),
    .down   (down),
    .n      (n),
    .duty   (duty),
    .rising (rising),
    .step   (step)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: duty level, whether auto is active, ramp direction and
  // cycles spent since the last auto step (or since entering auto).
  int m_duty;
  bit m_auto;
  bit m_dir_up;
  bit m_step;
  int m_since;

  function automatic logic [3:0] enc(input int level);
    return (level == 8) ? 4'h0 : 4'(level);
  endfunction

  task automatic model_reset();
    m_duty = DINIT; m_auto = 0; m_dir_up = 1; m_step = 0; m_since = 0;
  endtask

  task automatic model_edge(input logic md, input logic u, input logic d);
    bit md_eff;
    md_eff = md && AUTO_BUILD;
    m_step = 0;
    if (!m_auto) begin
      if (md_eff) begin
        m_auto = 1; m_since = 0; m_dir_up = (m_duty < DMAX);
      end else if (u && !d && m_duty < DMAX) begin
        m_duty++; m_step = 1;
      end else if (d && !u && m_duty > DMIN) begin
        m_duty--; m_step = 1;
      end
    end else if (!md_eff) begin
      m_auto = 0;
    end else begin
      m_since++;
      if (m_since == TDIV) begin
        m_since = 0; m_step = 1;
        m_duty = m_dir_up ? m_duty + 1 : m_duty - 1;
        if (m_duty == DMAX) m_dir_up = 0;
        if (m_duty == DMIN) m_dir_up = 1;
      end
    end
  endtask

  // Scoreboard compare.
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("duty", int'(duty), m_duty);
    check("n", int'(n), int'(enc(m_duty)));
    check("step", int'(step), int'(m_step));
    check("rising", int'(rising), int'(m_dir_up));
  endtask

  // Driver: inputs change on the falling edge, outputs checked 1 after rise.
  task automatic cycle(input logic md, input logic u, input logic d);
    @(negedge clk);
    mode = md; up = u; down = d;
    @(posedge clk);
    model_edge(md, u, d);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; mode = 1'b0; up = 1'b0; down = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Assert reset between clock edges and check outputs before the next edge.
  task automatic async_reset_check();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_duty", int'(duty), DINIT);
    check("async_n", int'(n), 0);
    check("async_step", int'(step), 0);
    check("async_rising", int'(rising), 1);
    model_reset();
    @(negedge clk);
    mode = 1'b0; up = 1'b0; down = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       md, u, d;
    logic [3:0] exp_duty;
    logic [3:0] exp_n;
    logic       exp_step;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit   md_r;
    int   seen_half;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 4'd9,  4'h9, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4'd10, 4'hA, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd10, 4'hA, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd9,  4'h9, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 4'd8,  4'h0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd8,  4'h0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'd7,  4'h7, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 4'd8,  4'h0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 4'd9,  4'h9, 1'b1};

    reset = 1'b1; mode = 1'b0; up = 1'b0; down = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_duty", int'(duty), 8);
    check("reset_n", int'(n), 0);
    check("reset_step", int'(step), 0);
    check("reset_rising", int'(rising), 1);

    // Table-driven manual vectors from the reset level.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].md, vecs[i].u, vecs[i].d);
      check($sformatf("vec%0d_duty", i), int'(duty), int'(vecs[i].exp_duty));
      check($sformatf("vec%0d_n", i), int'(n), int'(vecs[i].exp_n));
      check($sformatf("vec%0d_step", i), int'(step), int'(vecs[i].exp_step));
    end

    // Saturation at both bounds.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      check($sformatf("sat_up_step%0d", i), int'(step), (i <= 6) ? 1 : 0);
    end
    check("sat_up_duty", int'(duty), 14);
    check("sat_up_n", int'(n), 14);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1);
    check("sat_dn_duty", int'(duty), 2);
    check("sat_dn_n", int'(n), 2);

    // Simultaneous up and down at level 5.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    check("both_duty", int'(duty), 5);
    check("both_step", int'(step), 0);

`ifdef PWM_DUTY_AUTO_EN
    // Auto ramp from 12 with a 4-cycle tick.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("auto_enter_duty", int'(duty), 12);
    check("auto_enter_step", int'(step), 0);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (k == 3) check("auto_k3_duty", int'(duty), 12);
      if (k == 4) begin
        check("auto_k4_duty", int'(duty), 13);
        check("auto_k4_step", int'(step), 1);
      end
      if (k == 7) check("auto_k7_rising", int'(rising), 1);
      if (k == 8) begin
        check("auto_k8_duty", int'(duty), 14);
        check("auto_k8_rising", int'(rising), 0);
      end
      if (k == 12) check("auto_k12_duty", int'(duty), 13);
      if (k == 16) check("auto_k16_duty", int'(duty), 12);
    end
    seen_half = 0;
    for (int k = 0; k < 40 && m_duty != 6; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (m_duty == 8) begin
        check("ramp_half_n", int'(n), 0);
        seen_half = 1;
      end
    end
    check("ramp_half_seen", seen_half, 1);
    check("ramp_reach6", int'(duty), 6);
    cycle(1'b0, 1'b0, 1'b0);
    check("exit_hold_duty", int'(duty), 6);
    check("exit_hold_step", int'(step), 0);
    cycle(1'b0, 1'b1, 1'b0);
    check("exit_up_duty", int'(duty), 7);
`else
    // Manual-only build: mode is ignored.
    do_reset();
    for (int k = 0; k < 100; k++) cycle(1'b1, 1'b0, 1'b0);
    check("noauto_duty", int'(duty), 8);
    check("noauto_rising", int'(rising), 1);
    cycle(1'b1, 1'b1, 1'b0);
    check("noauto_up_duty", int'(duty), 9);
`endif

    // Async reset while ramping (or idling in the manual-only build).
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    async_reset_check();
    cycle(1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    md_r = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        md_r = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) md_r = ~md_r;
      cycle(md_r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

- Upstream control stage for the 4-bit PWM generator; produces its duty select `n`.
- Holds a duty level in sixteenths, clamped to 2..14.
- Two modes:
  - Manual: duty stepped by single-cycle up/down requests.
  - Auto "breathing": duty ramps between the bounds on a prescaled tick.
- Re-encodes the level into the PWM's select code, where 50 % is code 4'b0000.

## Interface

Parameters:
- `TICK_DIV`, default 5_000_000 — clk cycles per auto-ramp step; legal range 2 .. 2^24-1.
- `DUTY_MIN`, default 2 — lower clamp, in sixteenths.
- `DUTY_MAX`, default 14 — upper clamp, in sixteenths.
- `DUTY_INIT`, default 8 — level loaded at reset.

Ports:
- `clk` in 1 — sole clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `mode` in 1 — 0 = manual, 1 = auto ramp.
- `up` in 1 — synchronous step-up request, one cycle per step.
- `down` in 1 — synchronous step-down request.
- `n` out 4 — PWM select code, registered.
- `duty` out 4 — raw level, DUTY_MIN..DUTY_MAX, registered.
- `rising` out 1 — auto-ramp direction, 1 = increasing.
- `step` out 1 — one-cycle pulse, high in the cycle `duty` takes a new value.

## Operation

- Encoding: `n` = `duty`, except `duty` = 8 gives `n` = 4'b0000. Codes 0x1, 0x8 and 0xF are never driven.
- FSM states: `S_MANUAL`, `S_RISE`, `S_FALL`.
- S_MANUAL:
  - `up` && !`down` && `duty` < DUTY_MAX: increment.
  - `down` && !`up` && `duty` > DUTY_MIN: decrement.
  - Both high, or request at the bound: no change, no `step`.
  - `mode`=1 → S_RISE if `duty` < DUTY_MAX, else S_FALL.
- S_RISE: on tick, increment. If the new value is DUTY_MAX → S_FALL.
- S_FALL: on tick, decrement. If the new value is DUTY_MIN → S_RISE.
- In S_RISE / S_FALL, `mode`=0 → S_MANUAL; `duty` is held at its current value.
- `up` / `down` are ignored in auto states.
- Tick: prescale counter 0..TICK_DIV-1; tick when the count equals TICK_DIV-1, then it wraps to 0.
  - The counter is cleared in S_MANUAL, so the first auto step comes exactly TICK_DIV cycles after entering auto.
- `rising` = 1 in S_RISE. It holds its last value in S_MANUAL.
- Arithmetic is 4-bit unsigned; the clamp is checked before the add, so `duty` never wraps.

## Timing

- Reset values:
  - `duty` = DUTY_INIT; `n` = encoded DUTY_INIT, i.e. 4'b0000 for the default.
  - `rising` = 1; `step` = 0; state S_MANUAL; prescale count 0.
- Manual latency: `up` sampled high at edge k → `duty`, `n` and `step` update at edge k, visible in cycle k+1.
- Auto latency: `duty` changes on the edge where the tick is asserted.
- `mode` change is sampled at an edge and the state changes at that edge.
  - No duty change happens on the transition edge itself.
- Reset asserted mid-ramp: immediate return to the reset values, independent of clk.
- Reset deassertion is synchronised externally; no requirement inside this block.

## Configuration

- `PWM_DUTY_AUTO_EN` defined:
  - S_RISE, S_FALL and the prescale counter are built.
  - `mode` behaves as above.
- Undefined:
  - Only S_MANUAL exists and `mode` is ignored.
  - `rising` is tied to 1.
  - No prescale counter is synthesised, and `TICK_DIV` is unused.
- The port list is identical in both builds.

## Structure

- Shared package `pwm_pkg` holds:
  - state encodings: `S_MANUAL` = 2'd0, `S_RISE` = 2'd1, `S_FALL` = 2'd2;
  - `DUTY_W` = 4;
  - the encoding constant `DUTY_HALF_CODE` = 4'b0000.
- Sub-module `tick_gen`, parameter `DIV`:
  - inputs `clk`, `reset`, `clr`, `en`; output `tick`;
  - instantiated only under `PWM_DUTY_AUTO_EN`.
- Encoder is a registered function of the next `duty` inside this module, so `n` and `duty` change on the same edge.

## Test plan

- Reset with defaults:
  - `duty`=8, `n`=0x0, `step`=0.
  - Pulse `up` once → `duty`=9, `n`=0x9, `step` high one cycle.
- Manual saturation:
  - 10 `up` pulses from reset → `duty` stops at 14, `n`=0xE.
  - The 7th and later pulses give no `step`.
  - 20 `down` pulses → `duty` stops at 2, `n`=0x2.
- Simultaneous `up`+`down` at `duty`=5 → `duty` stays 5, no `step`.
- Auto ramp, `TICK_DIV`=4, `mode`=1 from `duty`=12:
  - `duty` goes 13, 14, 13, 12 … at 4-cycle spacing.
  - `rising` falls in the same cycle `duty` reaches 14.
  - The first step comes 4 cycles after `mode` rises.
  - The ramp passing 8 shows `n`=0x0.
- `mode` 1→0 at `duty`=6 → `duty` holds 6; `up` then gives 7.
- Async reset asserted mid-ramp, between clk edges → all outputs at reset values before the next edge.
- Build without `PWM_DUTY_AUTO_EN`, `mode`=1 for 100 cycles → `duty` unchanged; `up` still works.
